// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with immediate extension and load-use hazard detection.
// Optional load-use bubble counter when ID_EX_BUBBLE_CNT_EN is defined.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_read_data1,
  input  logic [DATA_W-1:0] id_read_data2,
  input  logic [15:0]       id_imm,
  input  logic              id_ext_sel,
  input  logic              id_ALUsrc,
  input  logic              id_RegDst,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_MemtoReg,
  input  logic [3:0]        id_ALUop,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              stall_if,
  output logic              ex_valid,
  output logic              ALUsrc,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemtoReg,
  output logic [3:0]        ALUop,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] ext_out,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_write_reg
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]       bubble_cnt
`endif
);

  logic [DATA_W-1:0] ext_next;
  logic              uses_rt;
  logic              load_use;
  logic              bubble;

  always_comb begin
    ext_next = '0;
    if (id_ext_sel)
      ext_next = {{(DATA_W-16){id_imm[15]}}, id_imm};
    else
      ext_next = {{(DATA_W-16){1'b0}}, id_imm};
  end

  assign uses_rt  = !id_ALUsrc || id_MemWrite;
  assign load_use = ex_valid && MemRead && (ex_rt != '0) && id_valid &&
                    ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  assign bubble   = flush || load_use || !id_valid;

  // Gated by reset_n so the front end is never held while the stage is in reset.
  assign stall_if = reset_n && (ex_stall || (!flush && load_use));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid     <= 1'b0;
      ALUsrc       <= 1'b0;
      RegWrite     <= 1'b0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      MemtoReg     <= 1'b0;
      ALUop        <= '0;
      read_data1   <= '0;
      read_data2   <= '0;
      ext_out      <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_write_reg <= '0;
    end else if (!ex_stall) begin
      if (bubble) begin
        ex_valid     <= 1'b0;
        ALUsrc       <= 1'b0;
        RegWrite     <= 1'b0;
        MemRead      <= 1'b0;
        MemWrite     <= 1'b0;
        MemtoReg     <= 1'b0;
        ALUop        <= '0;
        read_data1   <= '0;
        read_data2   <= '0;
        ext_out      <= '0;
        ex_rs        <= '0;
        ex_rt        <= '0;
        ex_write_reg <= '0;
      end else begin
        ex_valid     <= 1'b1;
        ALUsrc       <= id_ALUsrc;
        RegWrite     <= id_RegWrite;
        MemRead      <= id_MemRead;
        MemWrite     <= id_MemWrite;
        MemtoReg     <= id_MemtoReg;
        ALUop        <= id_ALUop;
        read_data1   <= id_read_data1;
        read_data2   <= id_read_data2;
        ext_out      <= ext_next;
        ex_rs        <= id_rs;
        ex_rt        <= id_rt;
        ex_write_reg <= id_RegDst ? id_rd : id_rt;
      end
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  // Only load-use bubbles count; flush and empty-slot bubbles are excluded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bubble_cnt <= '0;
    else if (!ex_stall && !flush && load_use && (bubble_cnt != '1))
      bubble_cnt <= bubble_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

- Pipeline register between decode and execute. Captures register-file operands, immediate and decoded controls, and drives the execute-stage operand mux: `ALUsrc`, `read_data2` and `ext_out`.
- Sign- or zero-extends the 16-bit immediate into `ext_out`.
- Detects load-use hazards and inserts bubbles; honours downstream stalls and branch flushes.

## Interface
Parameters:
- DATA_W, 32, operand/immediate-extension width
- REG_AW, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a real instruction
- id_rs, id_rt, id_rd  in  REG_AW  decoded register indices
- id_read_data1, id_read_data2  in  DATA_W  register-file read data
- id_imm  in  16  raw immediate
- id_ext_sel  in  1  1 = sign-extend, 0 = zero-extend
- id_ALUsrc, id_RegDst, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg  in  1  decoded controls
- id_ALUop  in  4  ALU operation
- ex_stall  in  1  execute/memory cannot accept; hold this stage
- flush  in  1  taken branch; discard the decode-stage instruction
- stall_if  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  execute stage holds a real instruction
- ALUsrc, RegWrite, MemRead, MemWrite, MemtoReg  out  1  registered controls
- ALUop  out  4  registered ALU operation
- read_data1, read_data2, ext_out  out  DATA_W  registered operands
- ex_rs, ex_rt, ex_write_reg  out  REG_AW  registered indices; `ex_write_reg` = `id_RegDst ? id_rd : id_rt` at capture

## Operation
- Immediate extension:
  - `ext_out` = {{(DATA_W-16){id_imm[15]}}, id_imm} when `id_ext_sel` = 1.
  - Otherwise `ext_out` = {(DATA_W-16)'b0, id_imm}.
- `uses_rt` = !id_ALUsrc || id_MemWrite.
- `load_use` = ex_valid && MemRead && ex_rt != 0 && id_valid && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt)).
- Bubble means: `ex_valid` = 0, all control outputs 0, all data and index outputs 0.
- Per-edge action, highest priority first:
  1. `ex_stall`: all outputs hold their values; `stall_if` = 1.
  2. `flush`: load a bubble; `stall_if` = 0.
  3. `load_use`: load a bubble; `stall_if` = 1.
  4. Otherwise: capture all ID inputs; `ex_valid` = `id_valid`; `stall_if` = 0.
- When `id_valid` = 0 on a normal capture, the stage loads a bubble.
- Index 0 never raises `load_use`.
- A load-use stall lasts exactly one cycle. The next cycle the load has advanced, `load_use` drops, and the dependent instruction is captured.

## Timing
- Capture latency: 1 cycle from ID inputs to registered outputs.
- `stall_if` is combinational from the current registered state and the ID inputs. It has no register delay.
- Reset (`reset_n` = 0, async):
  - Every output register = 0: `ex_valid` = 0, `ALUsrc` = 0, all controls 0, all data/index 0.
  - `stall_if` evaluates to 0 while in reset.
- Reset deasserted mid-stall: the first edge after release loads normally; no stale bubble.
- `flush` together with `load_use`: flush wins and `stall_if` = 0. The offending instruction is discarded, so no stall is needed.
- `ex_stall` together with `flush`: the stage holds; the flush must be held by its source until `ex_stall` drops.

## Configuration
- `ID_EX_BUBBLE_CNT_EN` defined:
  - Adds output `bubble_cnt` (16 bits), reset to 0.
  - Increments on every edge where a load-use bubble is loaded.
  - Saturates at 16'hFFFF.
  - Flush bubbles and `id_valid` = 0 bubbles are not counted.
- Macro undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Reset:
  - Stimulus: assert `reset_n` = 0 asynchronously mid-cycle with all ID inputs non-zero.
  - Response: all outputs 0 immediately, `stall_if` = 0; first capture happens after release.
- Immediate extension:
  - Stimulus: `id_imm` = 16'h8001 with `id_ext_sel` = 1, then the same with `id_ext_sel` = 0.
  - Response: `ext_out` = 32'hFFFF8001 next cycle, then 32'h00008001.
- Load-use:
  - Stimulus: load with `id_rt` = 5, then an R-type with `id_rs` = 5.
  - Response: `stall_if` = 1 for one cycle; a bubble with `ex_valid` = 0; the R-type captured on the following edge.
  - With the macro defined, `bubble_cnt` goes 0 → 1.
- Zero register:
  - Stimulus: load with `id_rt` = 0, then an instruction reading `rs` = 0.
  - Response: no stall, no bubble.
- Stall vs flush:
  - Stimulus: `ex_stall` = 1 together with `flush` = 1 for 2 cycles, then `flush` alone.
  - Response: outputs frozen for 2 cycles, then a bubble; `stall_if` goes 1, 1, 0.
